// File: rtl/decoder_cfg_sequencer.sv
// Boot/reconfiguration sequencer for the decoder register bus.
// Stops the decoder, streams a ROM table of {address,data} pairs into the
// register banks, then writes the run control word. Shares the bus with a
// host master that owns it whenever the sequencer is idle or done.
module decoder_cfg_sequencer #(
  parameter int          N_ENTRIES = 24,
  parameter int          ROM_LAT   = 2,
  parameter logic [31:0] CTRL_WORD = 32'h0000_0007,
  parameter int          AW        = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          go,
  input  logic          abort,
  input  logic          host_req,
  input  logic [4:0]    host_address,
  input  logic [31:0]   host_data,
  output logic          host_gnt,
  output logic          rom_rd,
  output logic [AW-1:0] rom_addr,
  input  logic [36:0]   rom_data,
  output logic          writ,
  output logic [4:0]    address,
  output logic [31:0]   data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STOP   = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_ENABLE = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ABORT  = 3'd7;

  localparam logic [AW-1:0] LAST_IDX = AW'(N_ENTRIES - 1);
  localparam logic [2:0]    CNT_LOAD = 3'(ROM_LAT - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          skip_q, skip_d;
  logic          writ_q, writ_d;
  logic [4:0]    address_q, address_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;

  logic idle_or_done;
  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);

  // Next-state and registered-bus decisions; a write is decided on the edge
  // that enters the state owning it, so it appears while that state is active.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    writ_d    = 1'b0;
    address_d = address_q;
    data_d    = data_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go && !abort) begin
          // go wins over a simultaneous host request; the host write is dropped
          state_d   = S_STOP;
          err_d     = 1'b0;
          index_d   = '0;
          writ_d    = 1'b1;
          address_d = 5'd0;
          data_d    = 32'd0;
        end else if (host_req) begin
          writ_d    = 1'b1;
          address_d = host_address;
          data_d    = host_data;
        end
      end
      S_STOP:  state_d = S_FETCH;
      S_FETCH: begin
        state_d = S_WAIT;
        cnt_d   = CNT_LOAD;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          // ROM word is valid now; entries aimed at the control bank are skipped
          state_d = S_WRITE;
          skip_d  = (rom_data[36:35] == 2'b00);
          if (rom_data[36:35] != 2'b00) begin
            writ_d    = 1'b1;
            address_d = rom_data[36:32];
            data_d    = rom_data[31:0];
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WRITE: begin
        if (skip_q) err_d = 1'b1;
        if (index_q == LAST_IDX) begin
          state_d   = S_ENABLE;
          writ_d    = 1'b1;
          address_d = 5'd0;
          data_d    = CTRL_WORD;
        end else begin
          state_d = S_FETCH;
          index_d = index_q + AW'(1);
        end
      end
      S_ENABLE: state_d = S_DONE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides any in-progress step: ROM data is dropped and the
    // decoder is stopped again.
    if (abort && !idle_or_done && (state_q != S_ABORT)) begin
      state_d   = S_ABORT;
      writ_d    = 1'b1;
      address_d = 5'd0;
      data_d    = 32'd0;
      err_d     = 1'b1;
    end
  end

  // State and bus registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      cnt_q     <= '0;
      skip_q    <= 1'b0;
      writ_q    <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      index_q   <= index_d;
      cnt_q     <= cnt_d;
      skip_q    <= skip_d;
      writ_q    <= writ_d;
      address_q <= address_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign writ     = writ_q;
  assign address  = address_q;
  assign data     = data_q;
  assign err      = err_q;
  assign busy     = !idle_or_done;
  assign host_gnt = idle_or_done;
  assign done     = (state_q == S_DONE);
  assign rom_rd   = (state_q == S_FETCH);
  assign rom_addr = index_q;

endmodule

// File: tb/tb_decoder_cfg_sequencer.sv
// Directed bench for decoder_cfg_sequencer (4 entries, ROM latency 2).
module tb_decoder_cfg_sequencer;

  localparam int NE = 4;
  localparam int NC = 24;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        go = 1'b0, abort = 1'b0, host_req = 1'b0;
  logic [4:0]  host_address = 5'h0A;
  logic [31:0] host_data = 32'h55;
  logic        host_gnt, rom_rd, writ, busy, done, err;
  logic [1:0]  rom_addr;
  logic [36:0] rom_data;
  logic [4:0]  address;
  logic [31:0] data;

  int tests = 0;
  int fails = 0;

  logic [36:0] rom_mem [NE];
  logic [36:0] rom_s1, rom_s2;

  logic        tr_writ [NC];
  logic [4:0]  tr_addr [NC];
  logic [31:0] tr_data [NC];
  logic        tr_rd   [NC];
  logic [1:0]  tr_radr [NC];
  logic        tr_done [NC];
  logic        tr_err  [NC];
  logic        tr_busy [NC];
  logic        tr_gnt  [NC];

  decoder_cfg_sequencer #(.N_ENTRIES(NE), .ROM_LAT(2), .CTRL_WORD(32'h7)) dut (
    .clk(clk), .reset_l(reset_l), .go(go), .abort(abort),
    .host_req(host_req), .host_address(host_address), .host_data(host_data),
    .host_gnt(host_gnt), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .writ(writ), .address(address), .data(data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Two-stage synchronous ROM; output is X except ROM_LAT cycles after a read.
  always @(posedge clk) begin
    rom_s1 <= rom_rd ? rom_mem[rom_addr] : 'x;
    rom_s2 <= rom_s1;
  end
  assign rom_data = rom_s2;

  // Cycle 0 is the cycle go is high; outputs are sampled mid-cycle.
  task automatic run_load(input int abort_at, input int host_a, input int host_b);
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++) begin
      go       = (c == 0);
      abort    = (c == abort_at);
      host_req = (c == host_a) || (c == host_b);
      @(negedge clk);
      tr_writ[c] = writ;   tr_addr[c] = address; tr_data[c] = data;
      tr_rd[c]   = rom_rd; tr_radr[c] = rom_addr;
      tr_done[c] = done;   tr_err[c]  = err;
      tr_busy[c] = busy;   tr_gnt[c]  = host_gnt;
      @(posedge clk); #1;
    end
    go = 1'b0; abort = 1'b0; host_req = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({writ, busy, done, err, host_gnt, rom_rd} !== 6'b000010) begin
      fails++;
      $display("FAIL reset_flags: got writ/busy/done/err/gnt/rd=%b want 000010",
               {writ, busy, done, err, host_gnt, rom_rd});
    end
    tests++;
    if (address !== 5'd0 || data !== 32'd0) begin
      fails++;
      $display("FAIL reset_bus: got %h/%h want 00/00000000", address, data);
    end
    @(posedge clk); #1 reset_l = 1'b1;
  endtask

  task automatic test_clean_load;
    int          wc [6] = '{1, 5, 9, 13, 17, 18};
    logic [4:0]  wa [6] = '{5'h00, 5'h08, 5'h10, 5'h18, 5'h09, 5'h00};
    logic [31:0] wd [6] = '{32'h0, 32'hA, 32'hB, 32'hC, 32'hD, 32'h7};
    run_load(-1, -1, -1);
    for (int c = 0; c < NC; c++) begin
      int k = -1;
      for (int i = 0; i < 6; i++) if (wc[i] == c) k = i;
      tests++;
      if (tr_writ[c] !== (k >= 0)) begin
        fails++;
        $display("FAIL clean_writ c=%0d: got %b want %b", c, tr_writ[c], k >= 0);
      end
      if (k >= 0) begin
        tests++;
        if (tr_addr[c] !== wa[k] || tr_data[c] !== wd[k]) begin
          fails++;
          $display("FAIL clean_bus c=%0d: got %h/%h want %h/%h",
                   c, tr_addr[c], tr_data[c], wa[k], wd[k]);
        end
      end
      tests++;
      if (tr_rd[c] !== (c == 2 || c == 6 || c == 10 || c == 14)) begin
        fails++;
        $display("FAIL clean_rom_rd c=%0d: got %b", c, tr_rd[c]);
      end
      if (tr_rd[c] === 1'b1) begin
        tests++;
        if (tr_radr[c] !== 2'((c - 2) / 4)) begin
          fails++;
          $display("FAIL clean_rom_addr c=%0d: got %0d want %0d", c, tr_radr[c], (c - 2) / 4);
        end
      end
      tests++;
      if (tr_done[c] !== (c >= 19) || tr_err[c] !== 1'b0) begin
        fails++;
        $display("FAIL clean_done_err c=%0d: got done=%b err=%b want done=%b err=0",
                 c, tr_done[c], tr_err[c], c >= 19);
      end
    end
  endtask

  task automatic test_illegal_entry;
    rom_mem[2] = {5'h00, 32'h0000_FFFF};
    run_load(-1, -1, -1);
    rom_mem[2] = {5'h18, 32'hC};
    for (int c = 0; c < NC; c++) begin
      logic ew = (c == 1 || c == 5 || c == 9 || c == 17 || c == 18);
      tests++;
      if (tr_writ[c] !== ew) begin
        fails++;
        $display("FAIL illegal_writ c=%0d: got %b want %b", c, tr_writ[c], ew);
      end
      tests++;
      if (tr_err[c] !== (c >= 14)) begin
        fails++;
        $display("FAIL illegal_err c=%0d: got %b want %b", c, tr_err[c], c >= 14);
      end
    end
    tests++;
    if (tr_addr[18] !== 5'h00 || tr_data[18] !== 32'h7 || tr_done[19] !== 1'b1) begin
      fails++;
      $display("FAIL illegal_enable: got %h/%h done=%b want 00/00000007 done=1",
               tr_addr[18], tr_data[18], tr_done[19]);
    end
  endtask

  task automatic test_abort;
    run_load(9, -1, -1);
    for (int c = 0; c < NC; c++) begin
      logic ew = (c == 1 || c == 5 || c == 9 || c == 10);
      tests++;
      if (tr_writ[c] !== ew || tr_rd[c] !== (c == 2 || c == 6)) begin
        fails++;
        $display("FAIL abort_trace c=%0d: got writ=%b rd=%b want writ=%b rd=%b",
                 c, tr_writ[c], tr_rd[c], ew, c == 2 || c == 6);
      end
      tests++;
      if (tr_err[c] !== (c == 0 || c >= 10)) begin
        fails++;
        $display("FAIL abort_err c=%0d: got %b want %b", c, tr_err[c], c == 0 || c >= 10);
      end
    end
    tests++;
    if (tr_addr[10] !== 5'h00 || tr_data[10] !== 32'h0) begin
      fails++;
      $display("FAIL abort_stop_write: got %h/%h want 00/00000000", tr_addr[10], tr_data[10]);
    end
    tests++;
    if (tr_busy[10] !== 1'b1 || tr_busy[11] !== 1'b0 || tr_done[NC-1] !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got busy10=%b busy11=%b done=%b want 1 0 0",
               tr_busy[10], tr_busy[11], tr_done[NC-1]);
    end
  endtask

  task automatic test_host_idle;
    @(posedge clk); #1 host_req = 1'b1;
    @(posedge clk); #1 host_req = 1'b0;
    @(negedge clk);
    tests++;
    if (writ !== 1'b1 || address !== 5'h0A || data !== 32'h55) begin
      fails++;
      $display("FAIL host_write: got %b %h/%h want 1 0a/00000055", writ, address, data);
    end
    @(negedge clk);
    tests++;
    if (writ !== 1'b0 || address !== 5'h0A || data !== 32'h55) begin
      fails++;
      $display("FAIL host_hold: got %b %h/%h want 0 0a/00000055", writ, address, data);
    end
  endtask

  task automatic test_host_arbitration;
    run_load(-1, 0, 3);
    tests++;
    if (tr_gnt[0] !== 1'b1 || tr_gnt[1] !== 1'b0) begin
      fails++;
      $display("FAIL arb_gnt: got %b%b want 10", tr_gnt[0], tr_gnt[1]);
    end
    tests++;
    if (tr_writ[1] !== 1'b1 || tr_addr[1] !== 5'h00 || tr_data[1] !== 32'h0) begin
      fails++;
      $display("FAIL arb_go_wins: got %b %h/%h want 1 00/00000000", tr_writ[1], tr_addr[1], tr_data[1]);
    end
    for (int c = 2; c < 5; c++) begin
      tests++;
      if (tr_writ[c] !== 1'b0) begin
        fails++;
        $display("FAIL arb_busy_ignored c=%0d: got %b want 0", c, tr_writ[c]);
      end
    end
    tests++;
    if (tr_addr[5] !== 5'h08 || tr_data[5] !== 32'hA || tr_done[NC-1] !== 1'b1) begin
      fails++;
      $display("FAIL arb_load: got %h/%h done=%b want 08/0000000a done=1",
               tr_addr[5], tr_data[5], tr_done[NC-1]);
    end
  endtask

  task automatic test_reset_mid_load;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1 || address !== 5'h08 || data !== 32'hA) begin
      fails++;
      $display("FAIL mid_pre: got busy=%b %h/%h want 1 08/0000000a", busy, address, data);
    end
    reset_l = 1'b0;
    #1;
    tests++;
    if ({writ, busy, done, err, rom_rd, host_gnt} !== 6'b000001 ||
        address !== 5'd0 || data !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset: got flags=%b %h/%h want 000001 00/00000000",
               {writ, busy, done, err, rom_rd, host_gnt}, address, data);
    end
    @(posedge clk); #1 reset_l = 1'b1;
    run_load(-1, -1, -1);
    tests++;
    if (tr_writ[1] !== 1'b1 || tr_addr[1] !== 5'h00 || tr_data[1] !== 32'h0) begin
      fails++;
      $display("FAIL restart_stop: got %b %h/%h want 1 00/00000000", tr_writ[1], tr_addr[1], tr_data[1]);
    end
    tests++;
    if (tr_rd[2] !== 1'b1 || tr_radr[2] !== 2'd0 || tr_done[19] !== 1'b1) begin
      fails++;
      $display("FAIL restart_index: got rd=%b addr=%0d done=%b want 1 0 1",
               tr_rd[2], tr_radr[2], tr_done[19]);
    end
  endtask

  initial begin
    rom_mem[0] = {5'h08, 32'hA};
    rom_mem[1] = {5'h10, 32'hB};
    rom_mem[2] = {5'h18, 32'hC};
    rom_mem[3] = {5'h09, 32'hD};
    test_reset();
    test_clean_load();
    test_illegal_entry();
    test_abort();
    test_host_idle();
    test_host_arbitration();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
